// File: rtl/result_buf_pkg.sv
// ---------------------------------------------------------------------------
// result_buf_pkg
// Shared types and constants for the result buffer writer.
//   state_t  : writer FSM states (IDLE/WRITE/FLUSH/DONE)
//   NUM_CLASS: number of legal classification results (0..9)
//   CLASS_W  : width of a classification result
//   CHKSUM_W : width of the optional run checksum (RESULT_CHECKSUM_EN)
// ---------------------------------------------------------------------------
package result_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_CLASS = 10;
    localparam int CLASS_W   = 4;
    localparam int CHKSUM_W  = 16;

    // A class outside 0..NUM_CLASS-1 is written anyway but flagged.
    function automatic logic class_is_illegal(input logic [CLASS_W-1:0] cls);
        return (cls >= CLASS_W'(NUM_CLASS));
    endfunction

endpackage

// File: rtl/result_buf_writer.sv
// ---------------------------------------------------------------------------
// result_buf_writer
// Producer side of the global-control done handshake. After a start pulse it
// accepts NUM_IMG classification results over valid/ready, writes them to
// consecutive result buffer addresses, then pulses buf_wr_done_o once.
//
// Ports:
//   clk_i          system clock
//   rstn_i         asynchronous, active-low reset
//   start_i        single-cycle start pulse (honoured only in IDLE)
//   res_valid_i    pipeline result valid
//   res_class_i    predicted class (legal 0..9)
//   res_ready_o    writer can accept a result (WRITE state only)
//   buf_we_o       result buffer write enable, one cycle per accepted result
//   buf_addr_o     result buffer write address
//   buf_wdata_o    result buffer write data, class zero-extended
//   buf_wr_done_o  one-cycle pulse, the cycle after the final write
//   busy_o         high from start acceptance until the done pulse ends
//   err_o          sticky for the run: a class > 9 was written
//   chksum_o       (RESULT_CHECKSUM_EN only) mod-2^16 sum of accepted classes
//
// Build option: define RESULT_CHECKSUM_EN to add chksum_o and its accumulator.
// ---------------------------------------------------------------------------
module result_buf_writer
    import result_buf_pkg::*;
#(
    parameter int NUM_IMG = 100,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               res_valid_i,
    input  logic [CLASS_W-1:0] res_class_i,
    output logic               res_ready_o,
    output logic               buf_we_o,
    output logic [ADDR_W-1:0]  buf_addr_o,
    output logic [DATA_W-1:0]  buf_wdata_o,
    output logic               buf_wr_done_o,
    output logic               busy_o,
    output logic               err_o
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [CHKSUM_W-1:0] chksum_o
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_IMG - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   count_reg;
    logic                buf_we_reg;
    logic [ADDR_W-1:0]   buf_addr_reg;
    logic [DATA_W-1:0]   buf_wdata_reg;
    logic                done_reg;
    logic                busy_reg;
    logic                err_reg;

    logic                start_acc;
    logic                accept;
    logic                last_accept;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        start_acc   = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    start_acc  = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // res_ready_o is 1 throughout WRITE, so valid alone accepts.
                if (res_valid_i) begin
                    accept = 1'b1;
                    if (count_reg == LAST_IDX) begin
                        last_accept = 1'b1;
                        state_next  = FLUSH;
                    end
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_reg     <= '0;
            buf_we_reg    <= 1'b0;
            buf_addr_reg  <= '0;
            buf_wdata_reg <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            buf_we_reg <= accept;
            // The done pulse lands in DONE, i.e. one cycle after the final
            // write (which is visible while the FSM sits in FLUSH).
            done_reg   <= (state_reg == FLUSH);
            busy_reg   <= (state_next != IDLE);

            if (start_acc) begin
                count_reg <= '0;
                err_reg   <= 1'b0;
            end

            if (accept) begin
                buf_addr_reg  <= count_reg;
                buf_wdata_reg <= DATA_W'(res_class_i);
                // Hold the count on the last accept so it never exceeds
                // NUM_IMG-1 (and cannot wrap when NUM_IMG == 2**ADDR_W).
                if (!last_accept) begin
                    count_reg <= count_reg + 1'b1;
                end
                if (class_is_illegal(res_class_i)) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [CHKSUM_W-1:0] chksum_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chksum_reg <= '0;
        end else if (start_acc) begin
            chksum_reg <= '0;
        end else if (accept) begin
            chksum_reg <= chksum_reg + CHKSUM_W'(res_class_i);
        end
    end

    assign chksum_o = chksum_reg;
`else
    // No checksum accumulator in this build.
`endif

    // Ready is a pure decode of the state register: no input-to-output path.
    assign res_ready_o   = (state_reg == WRITE);
    assign buf_we_o      = buf_we_reg;
    assign buf_addr_o    = buf_addr_reg;
    assign buf_wdata_o   = buf_wdata_reg;
    assign buf_wr_done_o = done_reg;
    assign busy_o        = busy_reg;
    assign err_o         = err_reg;

endmodule
